// File: rtl/boot_arb_pkg.sv
// Shared definitions for the boot memory arbiter: port identifiers,
// round-robin state encodings and the default write-protect boundary.
package boot_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Which port won the most recent granted cycle
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } rr_state_t;

  localparam logic [7:0] DEFAULT_WP_LIMIT = 8'h20;

endpackage

// File: rtl/boot_memory_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus of the boot
// memory arbiter. The slave modport is the arbiter's view; the master
// modport is the surrounding system (requesters plus memory).
interface boot_memory_arbiter_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8
);

  logic                    A_REQ;
  logic                    A_WR;
  logic [ADDRESS_BITS-1:0] A_ADDR;
  logic [BITS-1:0]         A_DIN;
  logic                    A_GNT;
  logic                    A_RVALID;
  logic [BITS-1:0]         A_DOUT;

  logic                    B_REQ;
  logic                    B_WR;
  logic [ADDRESS_BITS-1:0] B_ADDR;
  logic [BITS-1:0]         B_DIN;
  logic                    B_GNT;
  logic                    B_RVALID;
  logic [BITS-1:0]         B_DOUT;

  logic [ADDRESS_BITS-1:0] MEM_ADDRESS;
  logic [BITS-1:0]         MEM_DATA_IN;
  logic                    MEM_WR;
  logic [BITS-1:0]         MEM_DATA_OUT;
  logic                    WP_FAULT;

  modport slave (
    input  A_REQ, A_WR, A_ADDR, A_DIN,
    output A_GNT, A_RVALID, A_DOUT,
    input  B_REQ, B_WR, B_ADDR, B_DIN,
    output B_GNT, B_RVALID, B_DOUT,
    output MEM_ADDRESS, MEM_DATA_IN, MEM_WR,
    input  MEM_DATA_OUT,
    output WP_FAULT
  );

  modport master (
    output A_REQ, A_WR, A_ADDR, A_DIN,
    input  A_GNT, A_RVALID, A_DOUT,
    output B_REQ, B_WR, B_ADDR, B_DIN,
    input  B_GNT, B_RVALID, B_DOUT,
    input  MEM_ADDRESS, MEM_DATA_IN, MEM_WR,
    output MEM_DATA_OUT,
    input  WP_FAULT
  );

endinterface

// File: rtl/boot_arb_rr2.sv
// Two-way round-robin grant. Grants are combinational so the access is
// issued in the request cycle; the state remembers the last winner so a
// tie always goes to the other port.
module boot_arb_rr2
  import boot_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  rr_state_t state_reg;

  assign a_gnt = a_req & (~b_req | (state_reg == LAST_B));
  assign b_gnt = b_req & (~a_req | (state_reg == LAST_A));

  // Track the last winner; idle cycles leave it untouched
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= LAST_B;
    end else begin
      case (state_reg)
        LAST_A:  if (b_gnt) state_reg <= LAST_B;
        LAST_B:  if (a_gnt) state_reg <= LAST_A;
        default: state_reg <= LAST_B;
      endcase
    end
  end

endmodule

// File: rtl/boot_memory_arbiter.sv
// Shares one single-port sync-read boot memory between the CPU (port A)
// and the loader/DMA (port B). Holds the address/data/write muxes, the
// read-return tags and optional port-A write protection, enabled by
// defining BOOT_ARB_WP_EN.
module boot_memory_arbiter
  import boot_arb_pkg::*;
#(
  parameter int                      BITS         = 16,
  parameter int                      ADDRESS_BITS = 8,
  parameter logic [ADDRESS_BITS-1:0] WP_LIMIT     = ADDRESS_BITS'(DEFAULT_WP_LIMIT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  boot_memory_arbiter_if.slave  bus
);

`ifdef BOOT_ARB_WP_EN
  localparam bit WP_ENABLE = 1'b1;
`else
  localparam bit WP_ENABLE = 1'b0;
`endif

  logic                    a_gnt;
  logic                    b_gnt;
  logic                    sel;
  logic                    a_blocked;
  logic [ADDRESS_BITS-1:0] addr_hold_reg;
  logic                    a_rvalid_reg;
  logic                    b_rvalid_reg;
  logic                    wp_fault_reg;

  // Requests are masked during reset so no memory access is issued then
  boot_arb_rr2 u_rr2 (
    .CLK   (CLK),
    .RST   (RST),
    .a_req (bus.A_REQ & ~RST),
    .b_req (bus.B_REQ & ~RST),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign sel = b_gnt ? PORT_B : PORT_A;

  // A protected port-A write still consumes its slot; only the strobe is dropped.
  // Without write protection this term is constant 0, so WP_FAULT is tied low.
  assign a_blocked = WP_ENABLE && a_gnt && bus.A_WR && (bus.A_ADDR < WP_LIMIT);

  assign bus.A_GNT       = a_gnt;
  assign bus.B_GNT       = b_gnt;
  assign bus.MEM_ADDRESS = (a_gnt | b_gnt) ? ((sel == PORT_B) ? bus.B_ADDR : bus.A_ADDR)
                                           : addr_hold_reg;
  assign bus.MEM_DATA_IN = (sel == PORT_B) ? bus.B_DIN : bus.A_DIN;
  assign bus.MEM_WR      = (a_gnt & bus.A_WR & ~a_blocked) | (b_gnt & bus.B_WR);

  // Both ports see the raw memory output; RVALID says whose it is.
  // Reset also masks an already-tagged return in the reset cycle.
  assign bus.A_DOUT   = bus.MEM_DATA_OUT;
  assign bus.B_DOUT   = bus.MEM_DATA_OUT;
  assign bus.A_RVALID = a_rvalid_reg & ~RST;
  assign bus.B_RVALID = b_rvalid_reg & ~RST;
  assign bus.WP_FAULT = wp_fault_reg;

  // Address hold, read-return tags and write-protect fault pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_hold_reg <= '0;
      a_rvalid_reg  <= 1'b0;
      b_rvalid_reg  <= 1'b0;
      wp_fault_reg  <= 1'b0;
    end else begin
      if (a_gnt | b_gnt) begin
        addr_hold_reg <= bus.MEM_ADDRESS;
      end
      a_rvalid_reg <= a_gnt & ~bus.A_WR;
      b_rvalid_reg <= b_gnt & ~bus.B_WR;
      wp_fault_reg <= a_blocked;
    end
  end

endmodule
